// File: rtl/mult_fu_stage_if.sv
// Issue/complete-side bundle of the pipelined multiply FU.
// The FU uses the slave modport; issue and the complete stage sit on the master side.
interface mult_fu_stage_if #(
  parameter int PR   = 6,
  parameter int XLEN = 32
);
  typedef struct packed {
    logic            if_take_branch;
    logic [PR-1:0]   dest_pr;
    logic [XLEN-1:0] dest_value;
  } fu_complete_packet_t;

  logic                squash;
  logic                issue_valid;
  logic [1:0]          issue_func;
  logic [PR-1:0]       issue_pr;
  logic [XLEN-1:0]     rs1_value;
  logic [XLEN-1:0]     rs2_value;
  logic                fu_ready;
  logic                fu_finish;
  logic                fu_c_stall;
  fu_complete_packet_t fu_c_out;

  modport master (
    output squash, issue_valid, issue_func, issue_pr, rs1_value, rs2_value, fu_c_stall,
    input  fu_ready, fu_finish, fu_c_out
  );

  modport slave (
    input  squash, issue_valid, issue_func, issue_pr, rs1_value, rs2_value, fu_c_stall,
    output fu_ready, fu_finish, fu_c_out
  );
endinterface

// File: rtl/mult_fu_stage.sv
// Pipelined RV32M multiply unit: one rs2 slice is folded into a 64-bit partial sum per stage,
// with an elastic (bubble-collapsing) advance chain driven by the complete stage's stall bit.
module mult_fu_stage #(
  parameter int STAGES = 4,
  parameter int PR     = 6
) (
  input  logic            clock,
  input  logic            reset,
  mult_fu_stage_if.slave  fu
);
  localparam int          W          = 32 / STAGES;
  localparam int          LAST       = STAGES - 1;
  localparam logic [63:0] SLICE_MASK = (64'd1 << W) - 64'd1;
  localparam logic [1:0]  FN_MUL     = 2'b00;
  localparam logic [1:0]  FN_MULH    = 2'b01;
  localparam logic [1:0]  FN_MULHSU  = 2'b10;

  // Contribution of slice k of rs2; the top slice also carries the weight -2^32 of rs2 bit 32.
  function automatic logic [63:0] slice_term(input logic [32:0] a, input logic [32:0] b,
                                             input int k);
    logic [63:0] a64;
    logic [63:0] sl;
    logic [63:0] term;
    a64  = {{31{a[32]}}, a};
    sl   = ({32'd0, b[31:0]} >> (k * W)) & SLICE_MASK;
    term = (a64 * sl) << (k * W);
    if (k == LAST && b[32]) begin
      term = term - (a64 << 32);
    end else begin
      term = term;
    end
    return term;
  endfunction

  logic              valid_q [STAGES];
  logic              valid_d [STAGES];
  logic [1:0]        func_q  [STAGES];
  logic [1:0]        func_d  [STAGES];
  logic [PR-1:0]     pr_q    [STAGES];
  logic [PR-1:0]     pr_d    [STAGES];
  logic [32:0]       a_q     [STAGES];
  logic [32:0]       a_d     [STAGES];
  logic [32:0]       b_q     [STAGES];
  logic [32:0]       b_d     [STAGES];
  logic [63:0]       psum_q  [STAGES];
  logic [63:0]       psum_d  [STAGES];
  logic [STAGES-1:0] adv_s;
  logic [32:0]       a_ext_s;
  logic [32:0]       b_ext_s;
  logic [31:0]       res_s;

  // Advance chain: a stall only holds the last stage when it actually has a result.
  always_comb begin
    adv_s = '0;
    adv_s[LAST] = !valid_q[LAST] || !fu.fu_c_stall;
    for (int i = LAST - 1; i >= 0; i--) begin
      adv_s[i] = !valid_q[i] || adv_s[i+1];
    end
  end

  // Operand extension to 33 bits from the opcode.
  always_comb begin
    a_ext_s = {1'b0, fu.rs1_value};
    b_ext_s = {1'b0, fu.rs2_value};
    case (fu.issue_func)
      FN_MULH: begin
        a_ext_s[32] = fu.rs1_value[31];
        b_ext_s[32] = fu.rs2_value[31];
      end
      FN_MULHSU: a_ext_s[32] = fu.rs1_value[31];
      default:   a_ext_s[32] = 1'b0;
    endcase
  end

  // Next-state for every stage; squash wins over both issue and holding.
  always_comb begin
    valid_d = valid_q;
    func_d  = func_q;
    pr_d    = pr_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    if (adv_s[0]) begin
      valid_d[0] = fu.issue_valid && !fu.squash;
      func_d[0]  = fu.issue_func;
      pr_d[0]    = fu.issue_pr;
      a_d[0]     = a_ext_s;
      b_d[0]     = b_ext_s;
      psum_d[0]  = slice_term(a_ext_s, b_ext_s, 0);
    end else begin
      valid_d[0] = valid_q[0] && !fu.squash;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (adv_s[i]) begin
        valid_d[i] = valid_q[i-1] && !fu.squash;
        func_d[i]  = func_q[i-1];
        pr_d[i]    = pr_q[i-1];
        a_d[i]     = a_q[i-1];
        b_d[i]     = b_q[i-1];
        psum_d[i]  = psum_q[i-1] + slice_term(a_q[i-1], b_q[i-1], i);
      end else begin
        valid_d[i] = valid_q[i] && !fu.squash;
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
        func_q[i]  <= 2'b00;
        pr_q[i]    <= '0;
        a_q[i]     <= 33'd0;
        b_q[i]     <= 33'd0;
        psum_q[i]  <= 64'd0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= valid_d[i];
        func_q[i]  <= func_d[i];
        pr_q[i]    <= pr_d[i];
        a_q[i]     <= a_d[i];
        b_q[i]     <= b_d[i];
        psum_q[i]  <= psum_d[i];
      end
    end
  end

  // Result select reads only last-stage registers, so the packet has no input-to-output path.
  always_comb begin
    if (func_q[LAST] == FN_MUL) begin
      res_s = psum_q[LAST][31:0];
    end else begin
      res_s = psum_q[LAST][63:32];
    end
  end

  assign fu.fu_ready  = adv_s[0];
  assign fu.fu_finish = valid_q[LAST];
  assign fu.fu_c_out  = {1'b0, pr_q[LAST], res_s};
endmodule
